// File: rtl/ifetch_queue.sv
// Instruction fetch stage with a two-entry decoupling queue between the ROM
// and decode. Jumps flush the queue and redirect fetch. Hold freezes both
// fetch and delivery.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [31:0] head_addr;
    logic [31:0] head_inst;
    logic [31:0] tail_addr;
    logic [31:0] tail_inst;
    logic        push;
    logic        pop;
    logic        head_slot;

    // Redirect targets are word aligned, so the low address bits are ignored.
    logic unused_jump_bits;
    assign unused_jump_bits = ^jump_addr_i[1:0];

    assign rom_addr_o = fetch_pc;

    // Handshake, push/pop decisions and the decode-facing outputs.
    always_comb begin
        inst_valid_o = 1'b0;
        pop          = 1'b0;
        push         = 1'b0;
        head_slot    = 1'b0;
        inst_o       = NOP;
        inst_addr_o  = '0;
        if (!rst && !jump_i && !hold_i) begin
            inst_valid_o = (count != 2'd0);
            pop          = inst_valid_o && inst_ready_i;
            push         = (count != 2'd2) || pop;
        end
        // New entry lands in the head slot if the queue is (or becomes) empty.
        head_slot = (count == 2'd0) || ((count == 2'd1) && pop);
        if (!rst && (count != 2'd0)) begin
            inst_o      = head_inst;
            inst_addr_o = head_addr;
        end
    end

    // Fetch PC and occupancy; reset beats jump, jump beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
        end else if (jump_i) begin
            fetch_pc <= {jump_addr_i[31:2], 2'b00};
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage: a pop shifts tail into head; a push written after the
    // shift so a simultaneous refill of the head slot takes precedence.
    always_ff @(posedge clk) begin
        if (pop) begin
            head_addr <= tail_addr;
            head_inst <= tail_inst;
        end
        if (push) begin
            if (head_slot) begin
                head_addr <= fetch_pc;
                head_inst <= rom_inst_i;
            end else begin
                tail_addr <= fetch_pc;
                tail_inst <= rom_inst_i;
            end
        end
    end

endmodule
